// File: rtl/fsqrt_issue.sv
// fsqrt_issue
//   Issue and result-collection wrapper that sits directly in front of a
//   fixed-latency, non-stallable square-root pipeline.
//   - Tagged requests are accepted with a valid/ready handshake, and the
//     operand is passed straight through to the sqrt unit.
//   - A valid/tag shift register follows each operation down the pipeline.
//   - Results are caught in a small FIFO so that writeback can stall.
//   - Acceptance is credit based: a request is taken only while the number
//     of in-flight operations plus queued results is below FIFO_DEPTH. As a
//     result, the FIFO never overflows even though the pipeline cannot stop.
//
// Ports
//   clk, rst             clock, asynchronous active-high reset
//   req_valid/req_ready  request handshake
//   req_x, req_tag       operand and destination tag
//   sq_x / sq_y          operand to / result from the sqrt unit (LAT cycles)
//   res_valid/res_ready  result handshake (FIFO head)
//   res_y, res_tag       head result and its tag
//   busy                 any operation in flight or queued
module fsqrt_issue #(
  parameter int TAG_W      = 5,
  parameter int LAT        = 2,
  parameter int FIFO_DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [31:0]      req_x,
  input  logic [TAG_W-1:0] req_tag,
  output logic [31:0]      sq_x,
  input  logic [31:0]      sq_y,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [31:0]      res_y,
  output logic [TAG_W-1:0] res_tag,
  output logic             busy
);

  localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CNT_W = $clog2(FIFO_DEPTH + 1);
  localparam int OUT_W = $clog2(FIFO_DEPTH + LAT + 1);

  // Tracking shift register. Stage k corresponds to pipeline stage k.
  logic [LAT:1]     v_q;
  logic [TAG_W-1:0] t_q [1:LAT];

  // Result FIFO
  logic [31:0]      mem_y_q [FIFO_DEPTH];
  logic [TAG_W-1:0] mem_t_q [FIFO_DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;

  logic             fire;
  logic             push;
  logic             pop;
  logic [OUT_W-1:0] inflight;
  logic [OUT_W-1:0] outstanding;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    // Explicit wrap so that depths which are not a power of two also work.
    if (p == PTR_W'(FIFO_DEPTH - 1)) begin
      return '0;
    end
    return p + PTR_W'(1);
  endfunction

  // Credits: every operation in the pipe already owns a FIFO slot.
  always_comb begin
    inflight = '0;
    for (int k = 1; k <= LAT; k++) begin
      inflight = inflight + OUT_W'(v_q[k]);
    end
    outstanding = inflight + OUT_W'(count_q);
  end

  assign req_ready = !rst && (outstanding < OUT_W'(FIFO_DEPTH));
  assign fire      = req_valid && req_ready;
  assign sq_x      = req_x;
  assign busy      = (outstanding != '0);

  assign push      = v_q[LAT];
  assign res_valid = (count_q != '0);
  assign pop       = res_valid && res_ready;

  // Gating with the count hides stale storage. This makes the head outputs
  // read zero while the FIFO is empty and throughout reset, without needing
  // a reset on the storage array.
  assign res_y   = res_valid ? mem_y_q[rd_ptr_q] : '0;
  assign res_tag = res_valid ? mem_t_q[rd_ptr_q] : '0;

  always_comb begin
    wr_ptr_d = push ? ptr_inc(wr_ptr_q) : wr_ptr_q;
    rd_ptr_d = pop  ? ptr_inc(rd_ptr_q) : rd_ptr_q;
    count_d  = count_q;
    if (push && !pop) begin
      count_d = count_q + CNT_W'(1);
    end else if (!push && pop) begin
      count_d = count_q - CNT_W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      v_q      <= '0;
      for (int k = 1; k <= LAT; k++) begin
        t_q[k] <= '0;
      end
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      v_q[1] <= fire;
      t_q[1] <= req_tag;
      for (int k = 2; k <= LAT; k++) begin
        v_q[k] <= v_q[k-1];
        t_q[k] <= t_q[k-1];
      end
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage does not need a reset: a slot is only ever read after it has
  // been written, because the outputs are gated by the count.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_y_q[wr_ptr_q] <= sq_y;
      mem_t_q[wr_ptr_q] <= t_q[LAT];
    end
  end

endmodule
